// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the RV32M funct3 op encodings, the unit's FSM state enum and small
// decode helpers that report which operands are treated as signed.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // rs1 is signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input op_e op);
    logic s;
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  // rs2 is signed for MULH, DIV and REM (MULHSU treats rs2 as unsigned).
  function automatic logic op_signed_b(input op_e op);
    logic s;
    case (op)
      OP_MULH, OP_DIV, OP_REM: s = 1'b1;
      default:                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit for the execute stage.
// Multiplies by radix-2 shift-add and divides by restoring shift-subtract,
// both on unsigned magnitudes, then applies sign correction in one FIX cycle.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start_E    request strobe, accepted only in IDLE
//   funct3_E   op select (MUL..REMU)
//   opA, opB   rs1 / rs2 operands
//   flush_E    abort any op in flight
//   busy_E     unit occupied (stalls the pipeline)
//   done_E     one-cycle result-valid pulse
//   result_E   result, held until the next done_E
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_E,
  input  logic [2:0]      funct3_E,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            flush_E,
  output logic            busy_E,
  output logic            done_E,
  output logic [XLEN-1:0] result_E
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ONE2   = {{(2*XLEN-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [XLEN-1:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;         // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;         // multiplier->product low / dividend->quotient
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;       // final result needs negation
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  // Capture-time decode of the incoming request.
  op_e             op_in_s;
  logic            neg_a_s, neg_b_s, is_div_s, div0_s, ovf_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s;

  assign op_in_s  = op_e'(funct3_E);
  assign neg_a_s  = op_signed_a(op_in_s) & opA[XLEN-1];
  assign neg_b_s  = op_signed_b(op_in_s) & opB[XLEN-1];
  assign mag_a_s  = neg_a_s ? (~opA + ONE) : opA;
  assign mag_b_s  = neg_b_s ? (~opB + ONE) : opB;
  assign is_div_s = funct3_E[2];
  assign div0_s   = is_div_s & (opB == {XLEN{1'b0}});
  // Only the signed forms (funct3[0]=0) can overflow.
  assign ovf_s    = is_div_s & ~funct3_E[0] & (opA == MIN_NEG) & (opB == {XLEN{1'b1}});

  // Shared adder: shift-add in MUL, subtract-with-borrow-out in DIV.
  logic [XLEN:0]   add_a_s, add_b_s;
  logic            add_cin_s;
  logic [XLEN+1:0] add_sum_s;

  assign add_sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(XLEN+1){1'b0}}, add_cin_s};

  // Adder operand selection per iteration state.
  always_comb begin
    add_a_s   = {(XLEN+1){1'b0}};
    add_b_s   = {(XLEN+1){1'b0}};
    add_cin_s = 1'b0;
    case (state_q)
      ST_MUL: begin
        add_a_s = {1'b0, hi_q};
        add_b_s = lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}};
      end
      ST_DIV: begin
        // Shifted remainder minus divisor; carry out = no borrow.
        add_a_s   = {hi_q, lo_q[XLEN-1]};
        add_b_s   = ~{1'b0, mcand_q};
        add_cin_s = 1'b1;
      end
      default: begin
        add_cin_s = 1'b0;
      end
    endcase
  end

  // Sign-corrected result selection used in the FIX cycle.
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, fix_result_s;

  assign prod_s     = {hi_q, lo_q};
  assign prod_fix_s = neg_q ? (~prod_s + ONE2) : prod_s;
  assign quo_fix_s  = neg_q ? (~lo_q + ONE) : lo_q;
  assign rem_fix_s  = neg_q ? (~hi_q + ONE) : hi_q;

  // Pick the requested half / quotient / remainder.
  always_comb begin
    case (op_q)
      OP_MUL:                        fix_result_s = prod_fix_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_result_s = prod_fix_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_result_s = quo_fix_s;
      OP_REM, OP_REMU:               fix_result_s = rem_fix_s;
      default:                       fix_result_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (flush_E) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_E) begin
            op_d = op_in_s;
            if (div0_s) begin
              // Quotient all ones, remainder is the dividend.
              result_d = funct3_E[1] ? opA : {XLEN{1'b1}};
              done_d   = 1'b1;
              state_d  = ST_DONE;
            end else if (ovf_s) begin
              // Quotient is the dividend, remainder zero.
              result_d = funct3_E[1] ? {XLEN{1'b0}} : opA;
              done_d   = 1'b1;
              state_d  = ST_DONE;
            end else begin
              mcand_d = is_div_s ? mag_b_s : mag_a_s;
              lo_d    = is_div_s ? mag_a_s : mag_b_s;
              hi_d    = {XLEN{1'b0}};
              cnt_d   = CNT_INIT;
              // Remainder follows the dividend's sign; everything else the XOR.
              neg_d   = (is_div_s & funct3_E[1]) ? neg_a_s : (neg_a_s ^ neg_b_s);
              state_d = is_div_s ? ST_DIV : ST_MUL;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          hi_d  = add_sum_s[XLEN:1];
          lo_d  = {add_sum_s[0], lo_q[XLEN-1:1]};
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_MUL;
          end
        end
        ST_DIV: begin
          if (add_sum_s[XLEN+1]) begin
            hi_d = add_sum_s[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_DIV;
          end
        end
        ST_FIX: begin
          result_d = fix_result_s;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= {XLEN{1'b0}};
      hi_q     <= {XLEN{1'b0}};
      lo_q     <= {XLEN{1'b0}};
      cnt_q    <= {CW{1'b0}};
      neg_q    <= 1'b0;
      result_q <= {XLEN{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_E   = busy_q;
  assign done_E   = done_q;
  assign result_E = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_E;
  logic [2:0]  funct3_E;
  logic [31:0] opA, opB;
  logic        flush_E;
  logic        busy_E, done_E;
  logic [31:0] result_E;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_E(start_E), .funct3_E(funct3_E),
    .opA(opA), .opB(opB), .flush_E(flush_E),
    .busy_E(busy_E), .done_E(done_E), .result_E(result_E)
  );

  // Present a request for one cycle, then scramble the inputs.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_E = 1'b1; funct3_E = f; opA = a; opB = b;
    @(posedge clk); #1;
    start_E = 1'b0; funct3_E = 3'b000; opA = 32'h5A5A_A5A5; opB = 32'h0000_0003;
  endtask

  // Run one op; report result, latency (capture edge = 1), hold and idle status.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit held,
                        output bit idle_ok);
    logic [31:0] prev;
    prev = result_E;
    issue(f, a, b);
    lat  = 1;
    held = 1'b1;
    while (!done_E && lat < 100) begin
      if (result_E !== prev) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = result_E;
    @(posedge clk); #1;
    idle_ok = (busy_E === 1'b0) && (done_E === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_E = 1'b0; flush_E = 1'b0; funct3_E = 3'b000; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_E !== 1'b0 || done_E !== 1'b0 || result_E !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h, want 0 0 00000000", busy_E, done_E, result_E);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_vectors(input string name, input vec_t v [6]);
    logic [31:0] res; int lat; bit held, idle_ok;
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, res, lat, held, idle_ok);
      checks++;
      if (res !== v[i].exp) begin
        errors++;
        $display("FAIL %s[%0d] result: got %h expected %h", name, i, res, v[i].exp);
      end
      checks++;
      if (lat != v[i].lat) begin
        errors++;
        $display("FAIL %s[%0d] latency: got %0d expected %0d", name, i, lat, v[i].lat);
      end
      checks++;
      if (!idle_ok) begin
        errors++;
        $display("FAIL %s[%0d] idle after done: got busy=%b done=%b expected 0 0", name, i, busy_E, done_E);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v [6];
    v = '{'{3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
          '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
          '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
          '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
          '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34},
          '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34}};
    test_vectors("mul", v);
  endtask

  task automatic test_div();
    vec_t v [6];
    v = '{'{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34},
          '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34},
          '{3'b101, 32'd7,         32'd2,         32'd3,         34},
          '{3'b111, 32'd100,       32'd7,         32'd2,         34},
          '{3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34},
          '{3'b110, 32'd100,       32'hFFFF_FFF9, 32'd2,         34}};
    test_vectors("div", v);
  endtask

  task automatic test_special();
    vec_t v [6];
    v = '{'{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
          '{3'b110, 32'd5,         32'd0,         32'd5,         1},
          '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
          '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1},
          '{3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1},
          '{3'b111, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1}};
    test_vectors("special", v);
  endtask

  task automatic test_busy_ignore();
    int lat; int extra;
    issue(3'b101, 32'd100, 32'd7);
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    @(negedge clk); start_E = 1'b1; funct3_E = 3'b000; opA = 32'd2; opB = 32'd2;
    @(posedge clk); #1; start_E = 1'b0; lat++;
    while (!done_E && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (result_E !== 32'd14 || lat != 34) begin
      errors++;
      $display("FAIL busy_ignore: got result %h latency %0d expected 0000000e 34", result_E, lat);
    end
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done_E) extra++; end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_ignore queued: got %0d extra done pulses expected 0", extra);
    end
  endtask

  task automatic test_flush();
    int dones; bit changed;
    issue(3'b100, 32'd50, 32'd5);
    repeat (8) @(posedge clk);
    @(negedge clk); flush_E = 1'b1;
    @(posedge clk); #1; flush_E = 1'b0;
    checks++;
    if (busy_E !== 1'b0 || done_E !== 1'b0 || result_E !== 32'd14) begin
      errors++;
      $display("FAIL flush: got busy=%b done=%b result=%h expected 0 0 0000000e", busy_E, done_E, result_E);
    end
    dones = 0; changed = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done_E) dones++; if (result_E !== 32'd14) changed = 1'b1; end
    checks++;
    if (dones != 0 || changed) begin
      errors++;
      $display("FAIL flush aftermath: got %0d done pulses, result %h expected 0 and 0000000e", dones, result_E);
    end
    @(negedge clk); flush_E = 1'b1; start_E = 1'b1; funct3_E = 3'b000; opA = 32'd3; opB = 32'd3;
    @(posedge clk); #1; flush_E = 1'b0; start_E = 1'b0;
    checks++;
    if (busy_E !== 1'b0) begin
      errors++;
      $display("FAIL flush_wins busy: got %b expected 0", busy_E);
    end
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done_E) dones++; end
    checks++;
    if (dones != 0 || result_E !== 32'd14) begin
      errors++;
      $display("FAIL flush_wins: got %0d done pulses, result %h expected 0 and 0000000e", dones, result_E);
    end
  endtask

  task automatic test_rst_fix_back_to_back();
    logic [31:0] res; int lat; bit held, idle_ok;
    issue(3'b000, 32'd5, 32'd5);
    repeat (32) @(posedge clk);
    #1;
    checks++;
    if (busy_E !== 1'b1 || done_E !== 1'b0) begin
      errors++;
      $display("FAIL fix_state: got busy=%b done=%b expected 1 0", busy_E, done_E);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++;
    if (busy_E !== 1'b0 || done_E !== 1'b0 || result_E !== 32'h0) begin
      errors++;
      $display("FAIL rst_in_fix: got busy=%b done=%b result=%h expected 0 0 00000000", busy_E, done_E, result_E);
    end
    run_op(3'b000, 32'd3, 32'd4, res, lat, held, idle_ok);
    checks++;
    if (res !== 32'd12 || lat != 34 || !held || !idle_ok) begin
      errors++;
      $display("FAIL b2b mul: got %h lat %0d held %b idle %b expected 0000000c 34 1 1", res, lat, held, idle_ok);
    end
    run_op(3'b101, 32'd12, 32'd5, res, lat, held, idle_ok);
    checks++;
    if (res !== 32'd2 || lat != 34 || !held || !idle_ok) begin
      errors++;
      $display("FAIL b2b divu: got %h lat %0d held %b idle %b expected 00000002 34 1 1", res, lat, held, idle_ok);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_busy_ignore();
    test_flush();
    test_rst_fix_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
